// File: rtl/uart_boot_loader_if.sv
// RAM write port driven by the UART boot loader.
// The master side produces single-cycle write strobes with address and data.
interface uart_boot_loader_if #(
    parameter int ADDR_W = 12
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, mem_addr, mem_wdata);
    modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/uart_boot_loader.sv
// UART (8N1) program loader: MAGIC, 16-bit little-endian word count, then words (LE),
// written into RAM while the core is held in reset; core is released once the image is in.
module uart_boot_loader #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         ADDR_W       = 12,
    parameter logic [7:0] MAGIC        = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    uart_boot_loader_if.master mem,
    output logic               core_rst,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int             CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]    MAX_LEN = 17'(1) << ADDR_W;

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_REARM} rx_state_t;

    logic          rx_s1, rx_s2;
    rx_state_t     rx_st, rx_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          tick, byte_valid, frame_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
        end
    end

    // First sample lands half a bit after the edge, then every full bit (bit centres).
    assign tick = (cnt == ((rx_st == R_START) ? HALF_M1 : FULL_M1));

    always_comb begin
        rx_nxt     = rx_st;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        unique case (rx_st)
            R_IDLE:  if (!rx_s2) rx_nxt = R_START;
            R_START: if (tick) rx_nxt = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (tick && bit_idx == 3'd7) rx_nxt = R_STOP;
            R_STOP: begin
                if (tick) begin
                    if (rx_s2) begin
                        byte_valid = 1'b1;
                        rx_nxt     = R_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        rx_nxt    = R_REARM;
                    end
                end
            end
            R_REARM: if (rx_s2) rx_nxt = R_IDLE;
            default: rx_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_st   <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
        end else begin
            rx_st <= rx_nxt;
            cnt   <= (rx_nxt != rx_st || tick) ? '0 : cnt + 1'b1;
            if (rx_st == R_START)
                bit_idx <= '0;
            else if (rx_st == R_DATA && tick) begin
                bit_idx <= bit_idx + 3'd1;
                sh      <= {rx_s2, sh[7:1]};
            end
        end
    end

    // ---------------- loader ----------------
    typedef enum logic [2:0] {L_MAGIC, L_LEN_LO, L_LEN_HI, L_DATA, L_DONE} ld_state_t;

    ld_state_t     st, st_nxt;
    logic [7:0]    len_lo;
    logic [15:0]   len;
    logic [ADDR_W:0] word_cnt;
    logic [1:0]    byte_cnt;
    logic [23:0]   wbuf;
    logic [16:0]   len_full, wc_inc;
    logic          go, abort, wr, last_word;

    assign len_full  = {1'b0, sh, len_lo};
    assign wc_inc    = 17'(word_cnt) + 17'd1;
    assign wr        = (st == L_DATA) && byte_valid && (byte_cnt == 2'd3);
    assign last_word = (wc_inc == {1'b0, len});

    always_comb begin
        st_nxt = st;
        go     = 1'b0;
        abort  = 1'b0;
        unique case (st)
            L_MAGIC: begin
                if (byte_valid && sh == MAGIC) begin
                    st_nxt = L_LEN_LO;
                    go     = 1'b1;
                end
            end
            L_LEN_LO: begin
                if (frame_err)       abort  = 1'b1;
                else if (byte_valid) st_nxt = L_LEN_HI;
            end
            L_LEN_HI: begin
                if (frame_err) abort = 1'b1;
                else if (byte_valid) begin
                    if (len_full == 17'd0)        st_nxt = L_DONE;
                    else if (len_full > MAX_LEN)  abort  = 1'b1;
                    else                          st_nxt = L_DATA;
                end
            end
            L_DATA: begin
                if (frame_err)              abort  = 1'b1;
                else if (wr && last_word)   st_nxt = L_DONE;
            end
            L_DONE:  st_nxt = L_DONE;
            default: st_nxt = L_MAGIC;
        endcase
        if (abort) st_nxt = L_MAGIC;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st            <= L_MAGIC;
            len_lo        <= '0;
            len           <= '0;
            word_cnt      <= '0;
            byte_cnt      <= '0;
            wbuf          <= '0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            st         <= st_nxt;
            mem.mem_we <= wr;
            if (go) begin
                busy <= 1'b1;
                err  <= 1'b0;
            end
            if (abort) begin
                busy <= 1'b0;
                err  <= 1'b1;
            end
            // done trails the final write strobe by one cycle
            if (st == L_DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (st == L_LEN_LO && byte_valid) len_lo <= sh;
            if (st == L_LEN_HI && byte_valid) begin
                len      <= len_full[15:0];
                word_cnt <= '0;
                byte_cnt <= '0;
            end
            if (st == L_DATA && byte_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                wbuf     <= {sh, wbuf[23:8]};
                if (wr) begin
                    mem.mem_addr  <= word_cnt[ADDR_W-1:0];
                    mem.mem_wdata <= {sh, wbuf};
                    word_cnt      <= word_cnt + 1'b1;
                end
            end
        end
    end

    assign core_rst = ~done;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: directed and random byte streams driven on rx, compared
// against a byte-level parser model of the load protocol.
module tb_uart_boot_loader;
    localparam int CPB = 16;
    localparam int AW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic core_rst, busy, done, err;

    uart_boot_loader_if #(.ADDR_W(AW)) mem_bus ();

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx(rx), .mem(mem_bus),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;
    logic [35:0] act_q[$];
    logic [35:0] exp_q[$];

    // model state
    int m_st, m_len, m_wc, m_bc;
    logic [31:0] m_word;
    bit m_done, m_err, m_busy;

    always @(negedge clk) begin
        if (mem_bus.mem_we) act_q.push_back({mem_bus.mem_addr, mem_bus.mem_wdata});
        if (dut.byte_valid) bv_cnt++;
        if (dut.frame_err)  fe_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_len = 0; m_wc = 0; m_bc = 0; m_word = '0;
        m_done = 0; m_err = 0; m_busy = 0;
    endtask

    // Protocol parser: 0 wait magic, 1 len lo, 2 len hi, 3 data, 4 done
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            if (m_st >= 1 && m_st <= 3) begin
                m_err = 1; m_busy = 0; m_st = 0;
            end
            return;
        end
        case (m_st)
            0: if (b == 8'hA5) begin m_st = 1; m_busy = 1; m_err = 0; end
            1: begin m_len = int'(b); m_st = 2; end
            2: begin
                m_len = m_len + 256 * int'(b);
                if (m_len == 0) begin
                    m_st = 4; m_done = 1; m_busy = 0;
                end else if (m_len > (1 << AW)) begin
                    m_st = 0; m_err = 1; m_busy = 0;
                end else begin
                    m_st = 3; m_wc = 0; m_bc = 0; m_word = '0;
                end
            end
            3: begin
                m_word[8*m_bc +: 8] = b;
                m_bc++;
                if (m_bc == 4) begin
                    exp_q.push_back({m_wc[AW-1:0], m_word});
                    m_wc++;
                    m_bc = 0;
                    if (m_wc == m_len) begin m_st = 4; m_done = 1; m_busy = 0; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic tx_byte(input logic [7:0] b, input bit ok);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit ok = 1'b1);
        tx_byte(b, ok);
        model_byte(b, ok);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mem"}, {mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata}, 64'd0);
        chk({tag, "_flags"}, {core_rst, busy, done, err}, 64'b1000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b1;
        model_reset();
        act_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_result(input string tag);
        repeat (6) @(negedge clk);
        chk({tag, "_nwr"}, act_q.size(), exp_q.size());
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
            chk({tag, "_wr"}, act_q[i], exp_q[i]);
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_busy"}, busy, m_busy);
        chk({tag, "_core_rst"}, core_rst, !m_done);
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int bv0, fe0, nw, len;
        logic [7:0] b;
        model_reset();

        // 1: two-word image
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00);
        send_word(32'h0000_0013);
        send_word(32'hDEAD_BEEF);
        check_result("t1");

        // 2: noise before magic
        do_reset();
        send(8'h00); send(8'hFF); send(8'h5A);
        send(8'hA5); send(8'h01); send(8'h00);
        send_word(32'h1234_5678);
        check_result("t2");

        // 3: framing error mid-word, then a clean reload
        do_reset();
        send(8'hA5); send(8'h01); send(8'h00); send(8'h11); send(8'h22);
        send(8'h33, 1'b0);
        check_result("t3a");
        send(8'hA5); send(8'h01); send(8'h00);
        send_word(32'h1122_3344);
        check_result("t3b");

        // 4: zero length, then oversize length
        do_reset();
        send(8'hA5); send(8'h00); send(8'h00);
        check_result("t4a");
        do_reset();
        send(8'hA5); send(8'h11); send(8'h00);
        check_result("t4b");

        // 5: short low glitch while idle is discarded
        do_reset();
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        @(negedge clk) rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("t5_bv", bv_cnt, bv0);
        chk("t5_fe", fe_cnt, fe0);
        send(8'hA5); send(8'h01); send(8'h00);
        send_word(32'hCAFE_F00D);
        check_result("t5");

        // 6: async reset mid-word, then reload
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00);
        send_word(32'h8765_4321);
        send(8'hAA); send(8'hBB);
        check_result("t6a");
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_vals("t6_async");
        do_reset();
        send(8'hA5); send(8'h02); send(8'h00);
        send_word(32'h0BAD_CAFE);
        send_word(32'hFEED_FACE);
        check_result("t6b");

        // random streams
        for (int t = 0; t < 6; t++) begin
            do_reset();
            nw = $urandom_range(0, 2);
            for (int i = 0; i < nw; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hA5) b = 8'h00;
                send(b, $urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 1) == 1) begin
                send(8'hA5); send(8'h03); send(8'h00);
                nw = $urandom_range(0, 5);
                for (int i = 0; i < nw; i++) send(8'($urandom_range(0, 255)));
                send(8'($urandom_range(0, 255)), 1'b0);
            end
            case ($urandom_range(0, 7))
                0:       len = 0;
                1:       len = 17 + $urandom_range(0, 3);
                default: len = $urandom_range(1, 4);
            endcase
            send(8'hA5);
            send(8'(len));
            send(8'(len >> 8));
            if (len <= (1 << AW))
                for (int i = 0; i < len; i++) send_word($urandom);
            check_result("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
